// File: rtl/mips_ctrl_pkg.sv
// Shared opcode constants, sequencer state encoding and the datapath select
// bundle for the MIPS multi-cycle control sequencer.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_DONE   = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic [1:0] alu_op;
    } ctrl_sel_t;

    localparam ctrl_sel_t SEL_NONE = '0;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode decoder: maps a MIPS opcode to its datapath selects
// and flags whether the sequencer supports it.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_sel_t  sel,
    output logic       legal
);

    always_comb begin
        sel   = SEL_NONE;
        legal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                sel.reg_dst = 1'b1;
                sel.alu_op  = ALU_OP_FUNCT;
                legal       = 1'b1;
            end
            OP_LW: begin
                sel.alu_src    = 1'b1;
                sel.mem_to_reg = 1'b1;
                sel.alu_op     = ALU_OP_ADD;
                legal          = 1'b1;
            end
            OP_SW: begin
                sel.alu_src = 1'b1;
                sel.alu_op  = ALU_OP_ADD;
                legal       = 1'b1;
            end
            default: begin
                sel   = SEL_NONE;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_ctrl_sequencer.sv
// Handshaked multi-cycle control sequencer for the MIPS datapath.
// Optional retire counter port enabled by defining SEQ_RETIRE_COUNT_EN.
module mips_ctrl_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned MEM_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr_word,
    input  logic        abort,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        done,
    output logic        illegal
`ifdef SEQ_RETIRE_COUNT_EN
    ,
    output logic [31:0] retire_count
`endif
);

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);
    localparam logic [3:0] MEM_LOAD  = 4'(MEM_CYCLES - 1);

    seq_state_t  state;
    seq_state_t  next_state;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [31:0] instr_q;
    ctrl_sel_t   sel_q;
    ctrl_sel_t   sel_next;
    ctrl_sel_t   dec_sel;
    logic        legal_q;
    logic        legal_next;
    logic        dec_legal;
    logic        accept;
    logic        is_lw;
    logic        is_sw;
    logic        unused_instr_bits;

    // Decoding straight off the bus lets the selects settle during DECODE.
    mips_ctrl_decode u_decode (
        .opcode (instr_word[31:26]),
        .sel    (dec_sel),
        .legal  (dec_legal)
    );

    assign accept            = (state == S_IDLE) && instr_valid;
    assign is_lw             = (instr_q[31:26] == OP_LW);
    assign is_sw             = (instr_q[31:26] == OP_SW);
    assign unused_instr_bits = ^instr_q[25:0];

    assign reg_dst    = sel_q.reg_dst;
    assign alu_src    = sel_q.alu_src;
    assign mem_to_reg = sel_q.mem_to_reg;
    assign alu_op     = sel_q.alu_op;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        sel_next   = sel_q;
        legal_next = legal_q;

        case (state)
            S_IDLE: begin
                if (instr_valid) next_state = S_DECODE;
            end
            S_DECODE: begin
                if (abort)         next_state = S_IDLE;
                else if (!legal_q) next_state = S_DONE;
                else               next_state = S_EXEC;
            end
            S_EXEC: begin
                if (abort)                next_state = S_IDLE;
                else if (cnt == 4'd0)     next_state = (is_lw || is_sw) ? S_MEM : S_WB;
                else                      cnt_next = cnt - 4'd1;
            end
            S_MEM: begin
                if (abort)                next_state = S_IDLE;
                else if (cnt == 4'd0)     next_state = is_lw ? S_WB : S_DONE;
                else                      cnt_next = cnt - 4'd1;
            end
            S_WB: begin
                next_state = abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        // The shared hold counter is reloaded on every state change.
        if (next_state != state) begin
            if (next_state == S_EXEC)     cnt_next = EXEC_LOAD;
            else if (next_state == S_MEM) cnt_next = MEM_LOAD;
            else                          cnt_next = 4'd0;
        end

        if (accept) begin
            sel_next   = dec_sel;
            legal_next = dec_legal;
        end else if (next_state == S_IDLE) begin
            sel_next   = SEL_NONE;
            legal_next = 1'b0;
        end
    end

    // Outputs are registered from next_state so each strobe is high exactly
    // while its state is occupied and never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            instr_q     <= 32'd0;
            sel_q       <= SEL_NONE;
            legal_q     <= 1'b0;
            instr_ready <= 1'b1;
            reg_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_next;
            sel_q       <= sel_next;
            legal_q     <= legal_next;
            if (accept) instr_q <= instr_word;
            instr_ready <= (next_state == S_IDLE);
            reg_write   <= (next_state == S_WB);
            mem_read    <= (next_state == S_MEM) && is_lw;
            mem_write   <= (next_state == S_MEM) && is_sw;
            done        <= (next_state == S_DONE);
            illegal     <= (next_state == S_DONE) && !legal_q;
        end
    end

`ifdef SEQ_RETIRE_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_count <= 32'd0;
        end else if ((next_state == S_DONE) && (state != S_DONE) && legal_q) begin
            retire_count <= retire_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_ctrl_sequencer.sv
// Directed self-checking bench for mips_ctrl_sequencer; a second instance
// built with MEM_CYCLES=3 exercises the stretched store.
module tb_mips_ctrl_sequencer;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic        abort;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_to_reg;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        done;
    logic        illegal;

    logic        m3_valid;
    logic        m3_ready;
    logic [31:0] m3_word;
    logic        m3_abort;
    logic        m3_reg_dst;
    logic        m3_alu_src;
    logic        m3_mem_to_reg;
    logic [1:0]  m3_alu_op;
    logic        m3_reg_write;
    logic        m3_mem_read;
    logic        m3_mem_write;
    logic        m3_done;
    logic        m3_illegal;

`ifdef SEQ_RETIRE_COUNT_EN
    logic [31:0] retire_count;
    logic [31:0] m3_retire_count;
`endif

    int total;
    int bad;
    int exp_retire;

    mips_ctrl_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_word   (instr_word),
        .abort        (abort),
        .reg_dst      (reg_dst),
        .alu_src      (alu_src),
        .mem_to_reg   (mem_to_reg),
        .alu_op       (alu_op),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .done         (done),
        .illegal      (illegal)
`ifdef SEQ_RETIRE_COUNT_EN
        ,
        .retire_count (retire_count)
`endif
    );

    mips_ctrl_sequencer #(.EXEC_CYCLES(1), .MEM_CYCLES(3)) dut_m3 (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (m3_valid),
        .instr_ready  (m3_ready),
        .instr_word   (m3_word),
        .abort        (m3_abort),
        .reg_dst      (m3_reg_dst),
        .alu_src      (m3_alu_src),
        .mem_to_reg   (m3_mem_to_reg),
        .alu_op       (m3_alu_op),
        .reg_write    (m3_reg_write),
        .mem_read     (m3_mem_read),
        .mem_write    (m3_mem_write),
        .done         (m3_done),
        .illegal      (m3_illegal)
`ifdef SEQ_RETIRE_COUNT_EN
        ,
        .retire_count (m3_retire_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: sim time expired, required finish before 200000");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (instr_ready === 1'b1) break;
            tick();
        end
        total++;
        if (instr_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wait_idle: instr_ready=%b required=1", instr_ready);
        end
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        rst = 1'b1;
        tick();
        tick();
        obs = {instr_ready, reg_write, mem_read, mem_write, done, illegal};
        total++;
        if (obs !== 6'b100000) begin
            bad++;
            $display("[TB] FAIL reset_flags: got=%b required=100000", obs);
        end
        total++;
        if ({reg_dst, alu_src, mem_to_reg, alu_op} !== 5'b00000) begin
            bad++;
            $display("[TB] FAIL reset_sel: got=%b required=00000", {reg_dst, alu_src, mem_to_reg, alu_op});
        end
        total++;
        if (m3_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_m3_ready: got=%b required=1", m3_ready);
        end
`ifdef SEQ_RETIRE_COUNT_EN
        total++;
        if (retire_count !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_retire: got=%0d required=0", retire_count);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rtype();
        logic [5:0] obs;
        logic [5:0] exp;
        logic [4:0] exp_sel;
        wait_idle();
        instr_word  = 32'h00221820;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            exp     = {k == 5, k == 3, 1'b0, 1'b0, k == 4, 1'b0};
            exp_sel = (k <= 4) ? 5'b10010 : 5'b00000;
            obs     = {instr_ready, reg_write, mem_read, mem_write, done, illegal};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("[TB] FAIL rtype_flags k=%0d: got=%b required=%b", k, obs, exp);
            end
            total++;
            if ({reg_dst, alu_src, mem_to_reg, alu_op} !== exp_sel) begin
                bad++;
                $display("[TB] FAIL rtype_sel k=%0d: got=%b required=%b", k, {reg_dst, alu_src, mem_to_reg, alu_op}, exp_sel);
            end
`ifdef SEQ_RETIRE_COUNT_EN
            if (k == 4) begin
                exp_retire++;
                total++;
                if (retire_count !== 32'(exp_retire)) begin
                    bad++;
                    $display("[TB] FAIL rtype_retire: got=%0d required=%0d", retire_count, exp_retire);
                end
            end
`endif
            tick();
        end
    endtask

    task automatic test_lw();
        logic [5:0] obs;
        logic [5:0] exp;
        logic [4:0] exp_sel;
        wait_idle();
        instr_word  = 32'h8C040008;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            exp     = {k == 6, k == 4, k == 3, 1'b0, k == 5, 1'b0};
            exp_sel = (k <= 5) ? 5'b01100 : 5'b00000;
            obs     = {instr_ready, reg_write, mem_read, mem_write, done, illegal};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("[TB] FAIL lw_flags k=%0d: got=%b required=%b", k, obs, exp);
            end
            total++;
            if ({reg_dst, alu_src, mem_to_reg, alu_op} !== exp_sel) begin
                bad++;
                $display("[TB] FAIL lw_sel k=%0d: got=%b required=%b", k, {reg_dst, alu_src, mem_to_reg, alu_op}, exp_sel);
            end
            if (k == 5) exp_retire++;
            tick();
        end
    endtask

    task automatic test_sw_mem3();
        logic [5:0] obs;
        logic [5:0] exp;
        logic [4:0] exp_sel;
        for (int i = 0; i < 40; i++) begin
            if (m3_ready === 1'b1) break;
            tick();
        end
        total++;
        if (m3_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sw_wait_idle: m3_ready=%b required=1", m3_ready);
        end
        m3_word  = 32'hAC040008;
        m3_valid = 1'b1;
        tick();
        m3_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            exp     = {k == 7, 1'b0, 1'b0, (k >= 3) && (k <= 5), k == 6, 1'b0};
            exp_sel = (k <= 6) ? 5'b01000 : 5'b00000;
            obs     = {m3_ready, m3_reg_write, m3_mem_read, m3_mem_write, m3_done, m3_illegal};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("[TB] FAIL sw_flags k=%0d: got=%b required=%b", k, obs, exp);
            end
            total++;
            if ({m3_reg_dst, m3_alu_src, m3_mem_to_reg, m3_alu_op} !== exp_sel) begin
                bad++;
                $display("[TB] FAIL sw_sel k=%0d: got=%b required=%b", k, {m3_reg_dst, m3_alu_src, m3_mem_to_reg, m3_alu_op}, exp_sel);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic [5:0] obs;
        logic [5:0] exp;
        wait_idle();
        instr_word  = 32'h20010005;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            exp = {k == 3, 1'b0, 1'b0, 1'b0, k == 2, k == 2};
            obs = {instr_ready, reg_write, mem_read, mem_write, done, illegal};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("[TB] FAIL illegal_flags k=%0d: got=%b required=%b", k, obs, exp);
            end
            total++;
            if ({reg_dst, alu_src, mem_to_reg, alu_op} !== 5'b00000) begin
                bad++;
                $display("[TB] FAIL illegal_sel k=%0d: got=%b required=00000", k, {reg_dst, alu_src, mem_to_reg, alu_op});
            end
`ifdef SEQ_RETIRE_COUNT_EN
            if (k == 2) begin
                total++;
                if (retire_count !== 32'(exp_retire)) begin
                    bad++;
                    $display("[TB] FAIL illegal_retire: got=%0d required=%0d", retire_count, exp_retire);
                end
            end
`endif
            tick();
        end
    endtask

    task automatic test_abort();
        logic [5:0] obs;
        // abort while a load sits in MEM
        wait_idle();
        instr_word  = 32'h8C040008;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        total++;
        if (mem_read !== 1'b1) begin
            bad++;
            $display("[TB] FAIL abort_pre_mem_read: got=%b required=1", mem_read);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            obs = {instr_ready, reg_write, mem_read, mem_write, done, illegal};
            total++;
            if (obs !== 6'b100000) begin
                bad++;
                $display("[TB] FAIL abort_flags step=%0d: got=%b required=100000", k, obs);
            end
            total++;
            if ({reg_dst, alu_src, mem_to_reg, alu_op} !== 5'b00000) begin
                bad++;
                $display("[TB] FAIL abort_sel step=%0d: got=%b required=00000", k, {reg_dst, alu_src, mem_to_reg, alu_op});
            end
            tick();
        end
        // abort in IDLE does not block a simultaneous accept; the add completes
        instr_word  = 32'h00221820;
        instr_valid = 1'b1;
        abort       = 1'b1;
        tick();
        instr_valid = 1'b0;
        abort       = 1'b0;
        obs = {instr_ready, reg_write, mem_read, mem_write, done, illegal};
        total++;
        if (obs !== 6'b000000) begin
            bad++;
            $display("[TB] FAIL abort_idle_accept: got=%b required=000000", obs);
        end
        tick();
        tick();
        tick();
        obs = {instr_ready, reg_write, mem_read, mem_write, done, illegal};
        total++;
        if (obs !== 6'b000010) begin
            bad++;
            $display("[TB] FAIL abort_followup_done: got=%b required=000010", obs);
        end
        exp_retire++;
`ifdef SEQ_RETIRE_COUNT_EN
        total++;
        if (retire_count !== 32'(exp_retire)) begin
            bad++;
            $display("[TB] FAIL abort_retire: got=%0d required=%0d", retire_count, exp_retire);
        end
`endif
        // asynchronous reset while in EXEC
        wait_idle();
        instr_word  = 32'h00221820;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        total++;
        if ({instr_ready, reg_dst, alu_op} !== 4'b0110) begin
            bad++;
            $display("[TB] FAIL rst_pre_exec: got=%b required=0110", {instr_ready, reg_dst, alu_op});
        end
        #2;
        rst = 1'b1;
        #1;
        exp_retire = 0;
        obs = {instr_ready, reg_write, mem_read, mem_write, done, illegal};
        total++;
        if (obs !== 6'b100000) begin
            bad++;
            $display("[TB] FAIL rst_async_flags: got=%b required=100000", obs);
        end
        total++;
        if ({reg_dst, alu_src, mem_to_reg, alu_op} !== 5'b00000) begin
            bad++;
            $display("[TB] FAIL rst_async_sel: got=%b required=00000", {reg_dst, alu_src, mem_to_reg, alu_op});
        end
`ifdef SEQ_RETIRE_COUNT_EN
        total++;
        if (retire_count !== 32'd0) begin
            bad++;
            $display("[TB] FAIL rst_async_retire: got=%0d required=0", retire_count);
        end
`endif
        #2;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0] obs;
        logic [5:0] exp;
        logic [4:0] exp_sel;
        wait_idle();
        instr_word  = 32'h00221820;
        instr_valid = 1'b1;
        tick();
        for (int k = 1; k <= 17; k++) begin
            exp = {k inside {5, 11, 16, 17}, k inside {3, 9}, k == 8, k == 14, k inside {4, 10, 15}, 1'b0};
            if (k <= 4)                   exp_sel = 5'b10010;
            else if (k >= 6 && k <= 10)   exp_sel = 5'b01100;
            else if (k >= 12 && k <= 15)  exp_sel = 5'b01000;
            else                          exp_sel = 5'b00000;
            obs = {instr_ready, reg_write, mem_read, mem_write, done, illegal};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("[TB] FAIL b2b_flags k=%0d: got=%b required=%b", k, obs, exp);
            end
            total++;
            if ({reg_dst, alu_src, mem_to_reg, alu_op} !== exp_sel) begin
                bad++;
                $display("[TB] FAIL b2b_sel k=%0d: got=%b required=%b", k, {reg_dst, alu_src, mem_to_reg, alu_op}, exp_sel);
            end
            if (k inside {4, 10, 15}) exp_retire++;
            if (k == 1)  instr_word  = 32'h8C040008;
            if (k == 6)  instr_word  = 32'hAC040008;
            if (k == 12) instr_valid = 1'b0;
            tick();
        end
`ifdef SEQ_RETIRE_COUNT_EN
        total++;
        if (retire_count !== 32'(exp_retire)) begin
            bad++;
            $display("[TB] FAIL b2b_retire: got=%0d required=%0d", retire_count, exp_retire);
        end
`endif
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        exp_retire  = 0;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr_word  = 32'd0;
        abort       = 1'b0;
        m3_valid    = 1'b0;
        m3_word     = 32'd0;
        m3_abort    = 1'b0;
        $display("[TB] starting mips_ctrl_sequencer bench");
        test_reset();
        test_rtype();
        test_lw();
        test_sw_mem3();
        test_illegal();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
